// File: rtl/muldiv_pkg.sv
// Shared types for the multi-cycle multiply/divide unit: op encoding, FSM states, op width.
package muldiv_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or (with MULDIV_DIV_EN) restoring divide.
// Purely combinational; the caller holds the accumulator pair and the operand.
import muldiv_pkg::*;

module muldiv_step #(
  parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic             div_mode,
`endif
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opd,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

`ifdef MULDIV_DIV_EN
  logic [WIDTH+1:0] x, y, sum;
  logic             sub;

  // One shared adder: the extra top bit is the borrow that decides restore vs. keep.
  always_comb begin
    if (div_mode) begin
      x   = {1'b0, acc_hi, acc_lo[WIDTH-1]};
      y   = {2'b00, opd};
      sub = 1'b1;
    end else begin
      x   = {2'b00, acc_hi};
      y   = acc_lo[0] ? {2'b00, opd} : '0;
      sub = 1'b0;
    end
    sum = x + (sub ? ~y : y) + {{(WIDTH+1){1'b0}}, sub};
    if (div_mode) begin
      nxt_hi = sum[WIDTH+1] ? x[WIDTH-1:0] : sum[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ~sum[WIDTH+1]};
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end
`else
  logic [WIDTH:0] sum;

  always_comb begin
    sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
    nxt_hi = sum[WIDTH:1];
    nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
  end
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit with pipeline stall/flush handshake.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);

  state_e             state, state_nxt;
  op_e                op_i;
  logic [WIDTH-1:0]   cnt;
  logic               accept, err_nxt;
  logic               is_mul_op, is_div_op, is_signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH-1:0]   acc_hi, acc_lo, opd, step_hi, step_lo;
  logic               neg_lo;
  logic               wr_hi, wr_lo;
  logic [WIDTH-1:0]   hi_nxt, lo_nxt;
  logic [2*WIDTH-1:0] prod, prod_fix;
`ifdef MULDIV_DIV_EN
  logic               is_div, neg_hi, div0;
`endif

  assign op_i = op_e'(op);
  assign busy = (state == S_RUN) || (state == S_FIX);
  assign done = (state == S_DONE);

  always_comb begin
    is_mul_op    = (op_i == OP_MULT) || (op_i == OP_MULTU);
`ifdef MULDIV_DIV_EN
    is_div_op    = (op_i == OP_DIV) || (op_i == OP_DIVU);
`else
    is_div_op    = 1'b0;
`endif
    is_signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
    a_neg        = is_signed_op && a[WIDTH-1];
    b_neg        = is_signed_op && b[WIDTH-1];
    a_abs        = a_neg ? -a : a;
    b_abs        = b_neg ? -b : b;
  end

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    accept    = start && !flush && ((state == S_IDLE) || (state == S_DONE));
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (!start) begin
            state_nxt = S_IDLE;
          end else if (is_mul_op || is_div_op) begin
            state_nxt = S_RUN;
          end else begin
            state_nxt = S_DONE;
            err_nxt   = !((op_i == OP_MTHI) || (op_i == OP_MTLO));
          end
        end
        S_RUN:   if (cnt == CNT_LAST) state_nxt = S_FIX;
        S_FIX: begin
          state_nxt = S_DONE;
`ifdef MULDIV_DIV_EN
          err_nxt   = is_div && div0;
`endif
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Sign fix-up happens once, after the unsigned magnitude iterations finish.
  always_comb begin
    wr_hi    = accept && (op_i == OP_MTHI);
    wr_lo    = accept && (op_i == OP_MTLO);
    hi_nxt   = a;
    lo_nxt   = a;
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_lo ? -prod : prod;
    if ((state == S_FIX) && !flush) begin
      wr_hi            = 1'b1;
      wr_lo            = 1'b1;
      {hi_nxt, lo_nxt} = prod_fix;
`ifdef MULDIV_DIV_EN
      if (is_div) begin
        hi_nxt = neg_hi ? -acc_hi : acc_hi;
        lo_nxt = div0 ? '1 : (neg_lo ? -acc_lo : acc_lo);
      end
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      err   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      err   <= err_nxt;
      if (accept)              cnt <= '0;
      else if (state == S_RUN) cnt <= cnt + WIDTH'(1);
      if (wr_hi) hi <= hi_nxt;
      if (wr_lo) lo <= lo_nxt;
    end
  end

  // NOTE: the datapath is reloaded on every accept and is only observed after RUN,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_hi <= '0;
      acc_lo <= is_div_op ? a_abs : b_abs;
      opd    <= is_div_op ? b_abs : a_abs;
      neg_lo <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
      is_div <= is_div_op;
      neg_hi <= a_neg;
      div0   <= (b == '0);
`endif
    end else if (state == S_RUN) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
    .div_mode (is_div),
`endif
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo),
    .opd      (opd),
    .nxt_hi   (step_hi),
    .nxt_lo   (step_lo)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed table-driven bench for muldiv_unit (WIDTH=32) plus handshake corner sequences.
// Divide vectors apply when MULDIV_DIV_EN is defined; otherwise DIV/DIVU are expected to be reserved.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, err;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .err(err), .hi(hi), .lo(lo)
  );

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a, b, e_hi, e_lo;
    logic         e_err;
    int           e_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                     input logic [W-1:0] eh, input logic [W-1:0] el, input logic ee, input int lat);
    vec_t v;
    v.name = n; v.op = o; v.a = va; v.b = vb; v.e_hi = eh; v.e_lo = el; v.e_err = ee; v.e_lat = lat;
    vecs.push_back(v);
  endtask

  // Start in cycle 0; return the cycle in which done is first seen and the busy-cycle count.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                        output int lat, output int nbusy, output logic [W-1:0] rh,
                        output logic [W-1:0] rl, output logic re);
    @(negedge clk);
    op = o; a = va; b = vb; start = 1'b1;
    lat = -1; nbusy = 0; rh = '0; rl = '0; re = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        lat = k; rh = hi; rl = lo; re = err;
        break;
      end
    end
  endtask

  initial begin
    int           lat, nb, t1, t2, ndone, nbusy_seen;
    logic [W-1:0] rh, rl, lo_keep;
    logic         re;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.err",  err,  0);
    check("rst.hi",   hi,   0);
    check("rst.lo",   lo,   0);
    rst = 1'b0;

    add("mult_neg3x7",  OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34);
    add("multu_max",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34);
    add("mult_minmin",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34);
    add("mult_5xneg4",  OP_MULT,  32'd5,        32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC, 1'b0, 34);
    add("multu_shift",  OP_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0, 34);
    add("mthi",         OP_MTHI,  32'h12345678, 32'd0,        32'h12345678, 32'h23456780, 1'b0, 1);
    add("mtlo",         OP_MTLO,  32'hCAFEBABE, 32'd0,        32'h12345678, 32'hCAFEBABE, 1'b0, 1);
    add("rsv6",         OP_RSV6,  32'd1,        32'd2,        32'h12345678, 32'hCAFEBABE, 1'b1, 1);
    add("rsv7",         OP_RSV7,  32'd3,        32'd4,        32'h12345678, 32'hCAFEBABE, 1'b1, 1);
`ifdef MULDIV_DIV_EN
    add("div_neg7by2",  OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
    add("divu_by0",     OP_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 1'b1, 34);
    add("div_min_m1",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 34);
    add("div_7byneg2",  OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 34);
    add("divu_100by7",  OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34);
    add("div_neg8by0",  OP_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 34);
    add("divu_maxby16", OP_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 1'b0, 34);
`else
    add("div_rsv",      OP_DIV,   32'hFFFFFFF9, 32'd2,        32'h12345678, 32'hCAFEBABE, 1'b1, 1);
    add("divu_rsv",     OP_DIVU,  32'd7,        32'd0,        32'h12345678, 32'hCAFEBABE, 1'b1, 1);
`endif
    add("mult_zero",    OP_MULT,  32'd0,        32'hFFFFFFFF, 32'd0,        32'd0,        1'b0, 34);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, nb, rh, rl, re);
      check({vecs[i].name, ".lat"},  lat, vecs[i].e_lat);
      check({vecs[i].name, ".busy"}, nb,  vecs[i].e_lat - 1);
      check({vecs[i].name, ".hi"},   rh,  vecs[i].e_hi);
      check({vecs[i].name, ".lo"},   rl,  vecs[i].e_lo);
      check({vecs[i].name, ".err"},  re,  vecs[i].e_err);
    end

    // Back-to-back: second MULTU started in the DONE cycle of the first.
    @(negedge clk);
    op = OP_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    t1 = -1; t2 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin t1 = k; break; end
    end
    check("b2b.first_cycle", t1, 34);
    check("b2b.first_hi", hi, 32'hFFFFFFFE);
    check("b2b.first_lo", lo, 32'h00000001);
    op = OP_MULTU; a = 32'd2; b = 32'd3; start = 1'b1;
    for (int k = t1 + 1; k <= t1 + 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin t2 = k; break; end
    end
    check("b2b.second_cycle", t2, 68);
    check("b2b.second_hi", hi, 32'd0);
    check("b2b.second_lo", lo, 32'd6);

    // MTHI, then a MULT squashed at cycle 10 while a fresh start is offered.
    run_op(OP_MTHI, 32'h12345678, 32'd0, lat, nb, rh, rl, re);
    check("flush.mthi_hi", rh, 32'h12345678);
    lo_keep = lo;
    @(negedge clk);
    op = OP_MULT; a = 32'd3; b = 32'd5; start = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) ndone++;
    end
    flush = 1'b1; start = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd9;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush.busy_c11", busy, 0);
    nbusy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) ndone++;
      if (busy) nbusy_seen++;
      @(negedge clk);
    end
    check("flush.no_done", ndone, 0);
    check("flush.start_discarded", nbusy_seen, 0);
    check("flush.hi_kept", hi, 32'h12345678);
    check("flush.lo_kept", lo, lo_keep);

    // Flush and MTLO in the same cycle: flush wins, no write and no done.
    op = OP_MTLO; a = 32'hDEADBEEF; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_mtlo.done", done, 0);
    check("flush_mtlo.lo", lo, lo_keep);

    // Reset at cycle 20 of a long operation.
`ifdef MULDIV_DIV_EN
    op = OP_DIVU;
`else
    op = OP_MULTU;
`endif
    a = 32'd77; b = 32'd3; start = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) ndone++;
    end
    check("rst_mid.busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid.busy", busy, 0);
    check("rst_mid.done", done, 0);
    check("rst_mid.err",  err,  0);
    check("rst_mid.hi",   hi,   0);
    check("rst_mid.lo",   lo,   0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rst_mid.no_done", ndone, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
